// File: rtl/usb_rx_sequencer.sv
// Receive-path control unit for the USB full-speed receiver: SYNC check,
// per-byte FIFO write strobes, packet-length bound and sticky error reporting.
module usb_rx_sequencer #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int unsigned MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  input  logic       fifo_full,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic [6:0] byte_count
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    RCV_SYNC   = 4'd1,
    CHECK_SYNC = 4'd2,
    RCV_BYTE   = 4'd3,
    STORE      = 4'd4,
    BOUNDARY   = 4'd5,
    EOP_WAIT   = 4'd6,
    ERR_EOP    = 4'd7,
    ERR_IDLE   = 4'd8
  } state_e;

  state_e     state_q, state_d;
  logic       r_error_q, r_error_d;
  logic [6:0] byte_count_q, byte_count_d;
  logic       w_enable_q, w_enable_d;
  logic       sync_ok_q, sync_ok_d;

  logic eop_sample;
  assign eop_sample = eop && shift_enable;

  // NOTE: every variable assigned in this block gets a default first, so no
  // path through the case statement can leave a value held (latch inferred).
  always_comb begin
    state_d      = state_q;
    r_error_d    = r_error_q;
    byte_count_d = byte_count_q;
    w_enable_d   = 1'b0;
    sync_ok_d    = sync_ok_q;

    case (state_q)
      IDLE: begin
        if (d_edge) begin
          state_d      = RCV_SYNC;
          r_error_d    = 1'b0;
          byte_count_d = '0;
        end
      end

      RCV_SYNC: begin
        if (byte_received) begin
          sync_ok_d = (rcv_data == SYNC_BYTE);
          state_d   = CHECK_SYNC;
        end else if (eop_sample) begin
          state_d = ERR_EOP;
        end
      end

      CHECK_SYNC: state_d = sync_ok_q ? RCV_BYTE : ERR_EOP;

      RCV_BYTE: begin
        // The store decision is taken here and registered, so w_enable comes
        // straight from a flop during STORE with no path from fifo_full.
        if (byte_received) begin
          w_enable_d = !fifo_full && (byte_count_q != MAX_CNT);
          state_d    = STORE;
        end else if (eop_sample) begin
          state_d = ERR_EOP;
        end
      end

      STORE: begin
        if (w_enable_q) begin
          byte_count_d = byte_count_q + 7'd1;
          state_d      = BOUNDARY;
        end else begin
          state_d = ERR_EOP;
        end
      end

      BOUNDARY: begin
        if (shift_enable) state_d = eop ? EOP_WAIT : RCV_BYTE;
      end

      EOP_WAIT: if (d_edge) state_d = IDLE;

      ERR_EOP:  if (eop_sample) state_d = ERR_IDLE;

      ERR_IDLE: if (d_edge) state_d = IDLE;

      default:  state_d = IDLE;
    endcase

    if (state_d == ERR_EOP) r_error_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      r_error_q    <= 1'b0;
      byte_count_q <= '0;
      w_enable_q   <= 1'b0;
      sync_ok_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_error_q    <= r_error_d;
      byte_count_q <= byte_count_d;
      w_enable_q   <= w_enable_d;
      sync_ok_q    <= sync_ok_d;
    end
  end

  assign rcving     = (state_q != IDLE);
  assign w_enable   = w_enable_q;
  assign r_error    = r_error_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// Directed bench for usb_rx_sequencer (MAX_BYTES=2 so the length bound is
// reachable); expectations are hand-derived from the receive protocol.
module tb_usb_rx_sequencer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_edge, eop, shift_enable, byte_received, fifo_full;
  logic [7:0] rcv_data;
  logic       rcving, w_enable, r_error;
  logic [6:0] byte_count;

  int checks = 0;
  int errors = 0;
  int wen_count = 0;
  int wen_base;

  usb_rx_sequencer #(.SYNC_BYTE(8'h80), .MAX_BYTES(2)) dut (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop),
    .shift_enable(shift_enable), .byte_received(byte_received),
    .rcv_data(rcv_data), .fifo_full(fifo_full), .rcving(rcving),
    .w_enable(w_enable), .r_error(r_error), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (w_enable === 1'b1) wen_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic shifts(input int n);
    repeat (n) begin
      shift_enable = 1'b1; tick; shift_enable = 1'b0; tick;
    end
  endtask

  task automatic start_pkt(input string tag);
    d_edge = 1'b1; tick; d_edge = 1'b0;
    check({tag, "_rcving"}, rcving, 1);
    check({tag, "_rerr_clr"}, r_error, 0);
    check({tag, "_cnt_clr"}, byte_count, 0);
  endtask

  // Seven shifts then the byte_received pulse; leaves the FSM in CHECK_SYNC.
  task automatic sync_byte(input logic [7:0] v);
    shifts(7);
    rcv_data = v; byte_received = 1'b1; tick; byte_received = 1'b0;
  endtask

  // From RCV_BYTE: returns one cycle after the STORE cycle.
  task automatic data_byte(input string tag, input logic [7:0] v, input logic exp_wen);
    shifts(7);
    rcv_data = v; byte_received = 1'b1; tick; byte_received = 1'b0;
    check({tag, "_wen_latency"}, w_enable, exp_wen);
    tick;
    check({tag, "_wen_single"}, w_enable, 0);
  endtask

  task automatic boundary(input logic e);
    eop = e; shift_enable = 1'b1; tick; shift_enable = 1'b0; eop = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; d_edge = 0; eop = 0; shift_enable = 0; byte_received = 0;
    fifo_full = 0; rcv_data = 8'h00;
    #12;
    check("rst_rcving", rcving, 0);
    check("rst_wen", w_enable, 0);
    check("rst_rerr", r_error, 0);
    check("rst_cnt", byte_count, 0);
    n_rst = 1'b1;
    tick;
    check("idle_rcving", rcving, 0);

    // Good packet: SYNC, A5, 3C, EOP, J.
    wen_base = wen_count;
    start_pkt("good");
    sync_byte(8'h80); tick;
    check("good_sync_rerr", r_error, 0);
    data_byte("good_b1", 8'hA5, 1);
    check("good_cnt1", byte_count, 1);
    boundary(1'b0);
    data_byte("good_b2", 8'h3C, 1);
    check("good_cnt2", byte_count, 2);
    boundary(1'b1);
    check("good_eopwait_rcving", rcving, 1);
    check("good_eopwait_rerr", r_error, 0);
    d_edge = 1'b1; tick; d_edge = 1'b0;
    check("good_end_rcving", rcving, 0);
    check("good_end_rerr", r_error, 0);
    check("good_end_cnt", byte_count, 2);
    check("good_wen_total", wen_count - wen_base, 2);

    // Bad SYNC: 8'h84.
    wen_base = wen_count;
    start_pkt("badsync");
    sync_byte(8'h84);
    check("badsync_checkcyc_rerr", r_error, 0);
    tick;
    check("badsync_rerr", r_error, 1);
    check("badsync_rcving", rcving, 1);
    shifts(3);
    check("badsync_hold_rerr", r_error, 1);
    boundary(1'b1);
    check("badsync_erridle_rcving", rcving, 1);
    d_edge = 1'b1; tick; d_edge = 1'b0;
    check("badsync_end_rcving", rcving, 0);
    check("badsync_end_rerr_sticky", r_error, 1);
    check("badsync_wen_total", wen_count - wen_base, 0);

    // Mid-byte EOP: one byte stored, EOP at bit 3 of byte 2.
    wen_base = wen_count;
    start_pkt("midEOP");
    sync_byte(8'h80); tick;
    data_byte("mid_b1", 8'h5A, 1);
    boundary(1'b0);
    shifts(2);
    boundary(1'b1);
    check("mid_rerr", r_error, 1);
    check("mid_cnt", byte_count, 1);
    check("mid_rcving", rcving, 1);
    boundary(1'b1);
    d_edge = 1'b1; tick; d_edge = 1'b0;
    check("mid_end_rcving", rcving, 0);
    check("mid_wen_total", wen_count - wen_base, 1);

    // FIFO full when byte 1 completes.
    wen_base = wen_count;
    start_pkt("full");
    sync_byte(8'h80); tick;
    fifo_full = 1'b1;
    data_byte("full_b1", 8'h11, 0);
    fifo_full = 1'b0;
    check("full_rerr", r_error, 1);
    check("full_cnt", byte_count, 0);
    boundary(1'b1);
    d_edge = 1'b1; tick; d_edge = 1'b0;
    check("full_wen_total", wen_count - wen_base, 0);

    // Length overflow with MAX_BYTES=2.
    wen_base = wen_count;
    start_pkt("ovf");
    sync_byte(8'h80); tick;
    data_byte("ovf_b1", 8'h01, 1);
    boundary(1'b0);
    data_byte("ovf_b2", 8'h02, 1);
    check("ovf_cnt_at_max", byte_count, 2);
    check("ovf_rerr_before", r_error, 0);
    boundary(1'b0);
    data_byte("ovf_b3", 8'h03, 0);
    check("ovf_rerr", r_error, 1);
    check("ovf_cnt", byte_count, 2);
    check("ovf_wen_total", wen_count - wen_base, 2);
    boundary(1'b1);
    d_edge = 1'b1; tick; d_edge = 1'b0;
    check("ovf_end_rcving", rcving, 0);

    // Reset mid-packet, then a normal packet.
    start_pkt("rstmid");
    sync_byte(8'h80); tick;
    data_byte("rst_b1", 8'h77, 1);
    boundary(1'b0);
    shifts(2);
    #2 n_rst = 1'b0;
    #1;
    check("rstmid_rcving", rcving, 0);
    check("rstmid_cnt", byte_count, 0);
    check("rstmid_rerr", r_error, 0);
    check("rstmid_wen", w_enable, 0);
    tick;
    n_rst = 1'b1;
    tick;
    check("rstmid_idle", rcving, 0);
    wen_base = wen_count;
    start_pkt("after");
    sync_byte(8'h80); tick;
    data_byte("after_b1", 8'hC3, 1);
    check("after_cnt", byte_count, 1);
    boundary(1'b1);
    d_edge = 1'b1; tick; d_edge = 1'b0;
    check("after_rcving", rcving, 0);
    check("after_rerr", r_error, 0);
    check("after_wen_total", wen_count - wen_base, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
